// File: rtl/hex_display_scanner_if.sv
// Bus between the value/status source and the multiplexed hex display scanner.
// The source owns the value and control lines; the scanner owns the display drive lines.
interface hex_display_if #(
    parameter int unsigned DIGITS = 4
) ();
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp_mask;
    logic                load;
    logic                enable;
    logic                lz_blank;
    logic [7:0]          segments;
    logic [DIGITS-1:0]   digit_en;
    logic                frame;

    modport master (
        output value, dp_mask, load, enable, lz_blank,
        input  segments, digit_en, frame
    );

    modport slave (
        input  value, dp_mask, load, enable, lz_blank,
        output segments, digit_en, frame
    );
endinterface

// File: rtl/hex_display_scanner.sv
// Time-multiplexed N-digit hex display driver: shadows a value on load and scans
// one shared segment bus across one-hot digit enables, with leading-zero blanking.
module hex_display_scanner #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned CNT_W    = 10
) (
    input  logic          clk,
    input  logic          rst,
    hex_display_if.slave  bus
);

    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned VAL_W = 4 * DIGITS;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [VAL_W-1:0]  value_q, value_d;
    logic [DIGITS-1:0] dp_q, dp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        segments_q, segments_d;
    logic [DIGITS-1:0] digit_en_q, digit_en_d;
    logic              frame_q, frame_d;

    logic              cnt_wrap;
    logic [DIGITS:0]   lead_zero;
    logic [DIGITS-1:0] digit_sel;
    logic [3:0]        nibble;
    logic              dp_bit;
    logic              blank_cur;
    logic [6:0]        seg_bits;

    // Active-high g..a pattern for one hex nibble.
    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Shadow capture, dwell counter and digit index sequencing.
    always_comb begin
        value_d  = value_q;
        dp_d     = dp_q;
        cnt_d    = cnt_q + CNT_W'(1);
        idx_d    = idx_q;
        cnt_wrap = (cnt_q == CNT_LAST);

        if (bus.load) begin
            value_d = bus.value;
            dp_d    = bus.dp_mask;
        end

        if (cnt_wrap) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // lead_zero[k] is set when every nibble from the top down to k is zero.
    always_comb begin
        lead_zero         = '0;
        lead_zero[DIGITS] = 1'b1;
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            lead_zero[k] = lead_zero[k+1] && (value_q[4*k +: 4] == 4'h0);
        end
    end

    // Select the nibble, dp and blanking status of the digit currently scanned.
    always_comb begin
        digit_sel = '0;
        nibble    = 4'h0;
        dp_bit    = 1'b0;
        blank_cur = 1'b0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                digit_sel[k] = 1'b1;
                nibble       = value_q[4*k +: 4];
                dp_bit       = dp_q[k];
                blank_cur    = (k != 0) && lead_zero[k];
            end
        end
    end

    // Output register inputs, built from pre-edge state so outputs lag idx by one cycle.
    always_comb begin
        seg_bits   = hex_seg(nibble);
        segments_d = 8'h00;
        digit_en_d = '0;
        frame_d    = cnt_wrap && (idx_q == IDX_LAST);

        if (bus.lz_blank && blank_cur) begin
            seg_bits = 7'h00;
        end

        if (bus.enable) begin
            segments_d = {dp_bit, seg_bits};
            digit_en_d = digit_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q    <= '0;
            dp_q       <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            segments_q <= 8'h00;
            digit_en_q <= '0;
            frame_q    <= 1'b0;
        end else begin
            value_q    <= value_d;
            dp_q       <= dp_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            segments_q <= segments_d;
            digit_en_q <= digit_en_d;
            frame_q    <= frame_d;
        end
    end

    assign bus.segments = segments_q;
    assign bus.digit_en = digit_en_q;
    assign bus.frame    = frame_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench for hex_display_scanner: three configurations share one clock,
// stimulus pushes expected outputs, a negedge monitor pops and compares them.
module tb_hex_display_scanner;

    typedef struct {
        int unsigned dut;
        logic [7:0]  de;
        logic [7:0]  seg;
        logic        fr;
        string       tag;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] v_value;
    logic [7:0]  v_dp;
    logic        load;
    logic        en;
    logic        lz;

    exp_t        sb_q[$];
    int          compared;
    int          mismatched;

    int unsigned cur_dut;
    int          digits_c;
    int          div_c;
    int          pos;
    logic [7:0]  exp_seg [8];

    hex_display_if #(.DIGITS(2)) if_a ();
    hex_display_if #(.DIGITS(4)) if_b ();
    hex_display_if #(.DIGITS(3)) if_c ();

    assign if_a.value    = v_value[7:0];
    assign if_a.dp_mask  = v_dp[1:0];
    assign if_a.load     = load;
    assign if_a.enable   = en;
    assign if_a.lz_blank = lz;

    assign if_b.value    = v_value[15:0];
    assign if_b.dp_mask  = v_dp[3:0];
    assign if_b.load     = load;
    assign if_b.enable   = en;
    assign if_b.lz_blank = lz;

    assign if_c.value    = v_value[11:0];
    assign if_c.dp_mask  = v_dp[2:0];
    assign if_c.load     = load;
    assign if_c.enable   = en;
    assign if_c.lz_blank = lz;

    hex_display_scanner #(.DIGITS(2), .SCAN_DIV(4), .CNT_W(2)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a.slave)
    );

    hex_display_scanner #(.DIGITS(4), .SCAN_DIV(3), .CNT_W(2)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b.slave)
    );

    hex_display_scanner #(.DIGITS(3), .SCAN_DIV(2), .CNT_W(1)) u_c (
        .clk (clk),
        .rst (rst),
        .bus (if_c.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected per-digit segment codes while enabled.
    task automatic set_tab(input logic [7:0] s0, input logic [7:0] s1,
                           input logic [7:0] s2, input logic [7:0] s3);
        exp_seg[0] = s0;
        exp_seg[1] = s1;
        exp_seg[2] = s2;
        exp_seg[3] = s3;
        for (int i = 4; i < 8; i++) exp_seg[i] = 8'h00;
    endtask

    // One clock: predict the outputs the coming edge registers, then queue them.
    task automatic step(input string tag);
        exp_t e;
        int   d;
        e.dut = cur_dut;
        e.tag = tag;
        if (rst) begin
            e.de  = 8'h00;
            e.seg = 8'h00;
            e.fr  = 1'b0;
            pos   = 0;
        end else begin
            d     = pos / div_c;
            e.de  = en ? 8'(1 << d) : 8'h00;
            e.seg = en ? exp_seg[d] : 8'h00;
            e.fr  = (pos == digits_c * div_c - 1);
            pos   = (pos + 1) % (digits_c * div_c);
        end
        @(posedge clk);
        #1;
        sb_q.push_back(e);
    endtask

    // Monitor: compare registered outputs mid-cycle against the oldest prediction.
    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] a_de;
        logic [7:0] a_seg;
        logic       a_fr;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.dut)
                0: begin
                    a_de  = {6'b0, if_a.digit_en};
                    a_seg = if_a.segments;
                    a_fr  = if_a.frame;
                end
                1: begin
                    a_de  = {4'b0, if_b.digit_en};
                    a_seg = if_b.segments;
                    a_fr  = if_b.frame;
                end
                default: begin
                    a_de  = {5'b0, if_c.digit_en};
                    a_seg = if_c.segments;
                    a_fr  = if_c.frame;
                end
            endcase
            compared++;
            if (a_de !== e.de || a_seg !== e.seg || a_fr !== e.fr) begin
                mismatched++;
                $display("FAIL %s @%0t: got de=%b seg=%h frame=%b, want de=%b seg=%h frame=%b",
                         e.tag, $time, a_de, a_seg, a_fr, e.de, e.seg, e.fr);
            end
        end
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        rst     = 1'b1;
        load    = 1'b0;
        en      = 1'b1;
        lz      = 1'b0;
        v_value = 32'h0;
        v_dp    = 8'h0;

        // Two-digit decode; reset also wins over a simultaneous load.
        cur_dut = 0; digits_c = 2; div_c = 4; pos = 0;
        set_tab(8'h3F, 8'h3F, 8'h00, 8'h00);
        load = 1'b1; v_value = 32'hAB;
        repeat (3) step("rst_a");
        rst = 1'b0; load = 1'b0;
        step("rst_release");
        load = 1'b1; v_value = 32'hD2;
        step("load_d2");
        set_tab(8'h5B, 8'h5E, 8'h00, 8'h00);
        load = 1'b0;
        repeat (16) step("decode_d2");

        // Four digits: blanking, decimal point, enable gating, mid-scan load and reset.
        cur_dut = 1; digits_c = 4; div_c = 3;
        rst = 1'b1; lz = 1'b1;
        repeat (2) step("rst_b");
        rst = 1'b0; load = 1'b1; v_value = 32'h0030; v_dp = 8'h0;
        set_tab(8'h3F, 8'h00, 8'h00, 8'h00);
        step("lz_load");
        set_tab(8'h3F, 8'h4F, 8'h00, 8'h00);
        load = 1'b0;
        repeat (12) step("lz_0030");
        load = 1'b1; v_value = 32'h0000;
        step("lz_load0");
        set_tab(8'h3F, 8'h00, 8'h00, 8'h00);
        load = 1'b0;
        repeat (12) step("lz_0000");
        lz = 1'b0;
        set_tab(8'h3F, 8'h3F, 8'h3F, 8'h3F);
        repeat (6) step("lz_off");
        load = 1'b1; v_value = 32'h1234; v_dp = 8'b0100;
        step("dp_load");
        set_tab(8'h66, 8'h4F, 8'hDB, 8'h06);
        load = 1'b0;
        repeat (12) step("dp_1234");
        en = 1'b0;
        repeat (4) step("enable_off");
        en = 1'b1;
        repeat (6) step("enable_on");
        for (int i = 0; i < 20 && pos != div_c; i++) step("align_d1");
        load = 1'b1; v_value = 32'hFFFF; v_dp = 8'h0;
        step("ff_load");
        set_tab(8'h71, 8'h71, 8'h71, 8'h71);
        load = 1'b0;
        step("ff_digit1");
        repeat (6) step("ff_run");
        load = 1'b1; v_value = 32'h1234; rst = 1'b1;
        step("rst_with_load");
        rst = 1'b0; load = 1'b0;
        set_tab(8'h3F, 8'h3F, 8'h3F, 8'h3F);
        repeat (12) step("after_rst_load");

        // Three digits, two-cycle dwell: scan order and frame pulse spacing.
        cur_dut = 2; digits_c = 3; div_c = 2;
        rst = 1'b1;
        step("rst_c");
        rst = 1'b0; load = 1'b1; v_value = 32'h5A7;
        set_tab(8'h3F, 8'h3F, 8'h3F, 8'h00);
        step("load_5a7");
        set_tab(8'h07, 8'h77, 8'h6D, 8'h00);
        load = 1'b0;
        repeat (12) step("wrap_c");

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() > 0) begin
            mismatched++;
            $display("FAIL drain: %0d predictions left unchecked, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
